// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: widths, state encoding,
// default reset address and the address-alignment helper.
package fetch_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_t;

  // Clear the byte-offset bits so any loaded target is instruction aligned.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(INSTR_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit: issues word fetches, buffers one
// returned instruction for decode, and handles redirects at any point.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            out_valid,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  input  logic            out_ready,
  output logic [XLEN-1:0] pc
);

  fetch_state_t    state;
  logic            discard;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] target_pc;

  // Next-address candidates; the adder wraps naturally at 2^32.
  assign seq_pc    = pc + XLEN'(INSTR_BYTES);
  assign target_pc = align_pc(redirect_pc);

  // The request address is the fetch register itself, so it only moves when pc does.
  assign imem_req_addr = pc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      pc             <= RESET_PC;
      discard        <= 1'b0;
      imem_req_valid <= 1'b0;
      out_valid      <= 1'b0;
      out_instr      <= '0;
      out_pc         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (redirect_valid) pc <= target_pc;
          state          <= ST_REQ;
          imem_req_valid <= 1'b1;
        end

        ST_REQ: begin
          if (redirect_valid) pc <= target_pc;
          // A redirect racing an accepted request leaves a stale fetch in flight.
          if (imem_req_ready) begin
            state          <= ST_WAIT;
            imem_req_valid <= 1'b0;
            discard        <= redirect_valid;
          end
        end

        ST_WAIT: begin
          if (redirect_valid) begin
            pc <= target_pc;
            if (imem_rsp_valid) begin
              discard        <= 1'b0;
              state          <= ST_REQ;
              imem_req_valid <= 1'b1;
            end else begin
              discard <= 1'b1;
            end
          end else if (imem_rsp_valid) begin
            if (discard) begin
              discard        <= 1'b0;
              state          <= ST_REQ;
              imem_req_valid <= 1'b1;
            end else begin
              out_instr <= imem_rsp_data;
              out_pc    <= pc;
              pc        <= seq_pc;
              out_valid <= 1'b1;
              state     <= ST_HOLD;
            end
          end
        end

        ST_HOLD: begin
          // A redirect flushes the buffered instruction even if decode takes it.
          if (redirect_valid || out_ready) begin
            if (redirect_valid) pc <= target_pc;
            out_valid      <= 1'b0;
            state          <= ST_REQ;
            imem_req_valid <= 1'b1;
          end
        end

        default: begin
          state          <= ST_IDLE;
          imem_req_valid <= 1'b0;
          out_valid      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_fetch_unit;

  logic        clock;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_ready;

  logic        d0_req_valid, d0_out_valid;
  logic [31:0] d0_req_addr, d0_out_instr, d0_out_pc, d0_pc;
  logic        d1_req_valid, d1_out_valid;
  logic [31:0] d1_req_addr, d1_out_instr, d1_out_pc, d1_pc;

  int n_cmp = 0;
  int n_bad = 0;
  int n_delivered = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut0 (
    .clock(clock), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(d0_req_valid), .imem_req_addr(d0_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .out_valid(d0_out_valid),
    .out_instr(d0_out_instr), .out_pc(d0_out_pc), .out_ready(out_ready),
    .pc(d0_pc)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clock(clock), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(d1_req_valid), .imem_req_addr(d1_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .out_valid(d1_out_valid),
    .out_instr(d1_out_instr), .out_pc(d1_out_pc), .out_ready(out_ready),
    .pc(d1_pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Transaction-level model of dut0: one fetch in flight, one buffered instruction.
  logic        m_started = 1'b0;
  logic        m_outst   = 1'b0;
  logic        m_drop    = 1'b0;
  logic        m_buf     = 1'b0;
  logic [31:0] m_instr   = '0;
  logic [31:0] m_opc     = '0;
  logic [31:0] m_pc      = '0;

  function automatic logic [31:0] aligned(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_started = 1'b0; m_outst = 1'b0; m_drop = 1'b0; m_buf = 1'b0;
      m_instr = '0; m_opc = '0; m_pc = 32'h0;
    end else if (!m_started) begin
      m_started = 1'b1;
      if (redirect_valid) m_pc = aligned(redirect_pc);
    end else if (!m_outst && !m_buf) begin
      if (imem_req_ready) begin
        m_outst = 1'b1;
        m_drop  = redirect_valid;
      end
      if (redirect_valid) m_pc = aligned(redirect_pc);
    end else if (m_outst) begin
      if (redirect_valid) begin
        m_pc = aligned(redirect_pc);
        if (imem_rsp_valid) begin m_outst = 1'b0; m_drop = 1'b0; end
        else m_drop = 1'b1;
      end else if (imem_rsp_valid) begin
        m_outst = 1'b0;
        if (m_drop) m_drop = 1'b0;
        else begin
          m_buf = 1'b1; m_instr = imem_rsp_data; m_opc = m_pc; m_pc = m_pc + 32'd4;
        end
      end
    end else begin
      if (redirect_valid) begin
        m_buf = 1'b0; m_pc = aligned(redirect_pc);
      end else if (out_ready) begin
        m_buf = 1'b0; n_delivered++;
      end
    end
  end

  // Every-cycle comparison of dut0 against the model, away from the active edge.
  always @(negedge clock) begin
    check("req_valid", 32'(d0_req_valid), 32'(m_started && !m_outst && !m_buf));
    check("req_addr",  d0_req_addr, m_pc);
    check("pc",        d0_pc, m_pc);
    check("out_valid", 32'(d0_out_valid), 32'(m_buf));
    check("out_instr", d0_out_instr, m_instr);
    check("out_pc",    d0_out_pc, m_opc);
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic fetch_one(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] data);
    check("seq_req_valid", 32'(d0_req_valid), 32'd1);
    check("seq_req_addr0", d0_req_addr, a0);
    check("seq_req_addr1", d1_req_addr, a1);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    check("seq_wait_no_out", 32'(d0_out_valid), 32'd0);
    imem_rsp_valid = 1'b1; imem_rsp_data = data;
    tick();
    imem_rsp_valid = 1'b0;
    check("seq_out_valid", 32'(d0_out_valid), 32'd1);
    check("seq_out_pc0",   d0_out_pc, a0);
    check("seq_out_instr", d0_out_instr, data);
    check("seq_out_pc1",   d1_out_pc, a1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; out_ready = 1'b0;
    reset = 1'b1;
    #2 reset = 1'b0;
    tick(); tick();
    check("rst_req_valid", 32'(d0_req_valid), 32'd0);
    check("rst_out_valid", 32'(d0_out_valid), 32'd0);
    check("rst_addr0",     d0_req_addr, 32'h0);
    check("rst_addr1",     d1_req_addr, 32'hFFFF_FFFC);
    check("rst_out_instr", d0_out_instr, 32'h0);
    reset = 1'b1;
    tick();

    // Memory stalls: the pending request must not move.
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(d0_req_valid), 32'd1);
      check("stall_addr",  d0_req_addr, 32'h0);
      tick();
    end

    // Back-to-back sequential fetches; dut1 wraps past the top of memory.
    fetch_one(32'h0, 32'hFFFF_FFFC, 32'h1111_0001);
    fetch_one(32'h4, 32'h0000_0000, 32'h2222_0002);
    fetch_one(32'h8, 32'h0000_0004, 32'h3333_0003);

    // Redirect while waiting; the in-flight response must be dropped.
    check("rdw_pre_addr", d0_req_addr, 32'hC);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0;
    check("rdw_pc_aligned", d0_pc, 32'h100);
    check("rdw_no_out_a",   32'(d0_out_valid), 32'd0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 1'b0;
    check("rdw_no_out_b",   32'(d0_out_valid), 32'd0);
    check("rdw_req_valid",  32'(d0_req_valid), 32'd1);
    check("rdw_req_addr",   d0_req_addr, 32'h100);

    // Redirect in HOLD beats a same-cycle decode accept.
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hCAFE_0100;
    tick();
    imem_rsp_valid = 1'b0;
    check("rdh_out_valid", 32'(d0_out_valid), 32'd1);
    check("rdh_out_pc",    d0_out_pc, 32'h100);
    redirect_valid = 1'b1; redirect_pc = 32'h200; out_ready = 1'b1;
    tick();
    redirect_valid = 1'b0; out_ready = 1'b0;
    check("rdh_flushed",   32'(d0_out_valid), 32'd0);
    check("rdh_req_valid", 32'(d0_req_valid), 32'd1);
    check("rdh_req_addr",  d0_req_addr, 32'h200);

    // Reset during WAIT, then a stale response after release.
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    #1 reset = 1'b0;
    #1;
    check("mid_rst_req_valid", 32'(d0_req_valid), 32'd0);
    check("mid_rst_addr0",     d0_req_addr, 32'h0);
    check("mid_rst_addr1",     d1_req_addr, 32'hFFFF_FFFC);
    tick();
    reset = 1'b1;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_BAD0;
    tick();
    check("stale_out_valid", 32'(d0_out_valid), 32'd0);
    check("stale_req_valid", 32'(d0_req_valid), 32'd1);
    check("stale_req_addr",  d0_req_addr, 32'h0);
    tick();
    check("stale_out_valid2", 32'(d0_out_valid), 32'd0);
    imem_rsp_valid = 1'b0;

    // Randomized traffic, including rare reset pulses.
    for (int i = 0; i < 4000; i++) begin
      tick();
      #1;
      reset          = ($urandom_range(0, 399) != 0);
      redirect_valid = ($urandom_range(0, 99) < 8);
      redirect_pc    = $urandom();
      imem_req_ready = ($urandom_range(0, 1) == 1);
      imem_rsp_valid = ($urandom_range(0, 9) < 3);
      imem_rsp_data  = $urandom();
      out_ready      = ($urandom_range(0, 9) < 6);
    end
    tick();
    #1 reset = 1'b1; redirect_valid = 1'b0;
    tick();
    check("delivered_some", 32'(n_delivered > 20), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
